// File: rtl/fc_pkg.sv
// +-------------------------------------------------------------------------+
// | fc_pkg : shared types and helpers for the fully-connected sequencer     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package fc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  function automatic int acc_width(input int width, input int in);
    return width * 2 + $clog2(in);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_sequencer_relu.sv
// +-------------------------------------------------------------------------+
// | relu : two-way select; y = sel ? b : a                                  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module relu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/fc_sequencer.sv
// +-------------------------------------------------------------------------+
// | fc_sequencer : streams activations/weights through one MAC per neuron   |
// | and emits ReLU results. Optional bias load: define FC_BIAS_EN.          |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module fc_sequencer
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 400,
  parameter int OUT   = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(IN)-1:0]                x_addr,
  input  logic [WIDTH-1:0]                     x_data,
  output logic [$clog2(IN*OUT)-1:0]            w_addr,
  input  logic [WIDTH-1:0]                     w_data,
`ifdef FC_BIAS_EN
  input  logic [2*WIDTH-1:0]                   b_data,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(OUT)-1:0]               out_idx,
  output logic [WIDTH*2+$clog2(IN)-1:0]        out_data
);

  localparam int ACC_W = WIDTH*2 + $clog2(IN);
  localparam int KW    = $clog2(IN);
  localparam int NW    = $clog2(OUT);
  localparam int AW    = $clog2(IN*OUT);
  localparam int EXT_W = ACC_W - 2*WIDTH;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NW-1:0]    n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic signed [2*WIDTH-1:0] w_x_ext, w_w_ext, w_prod;
  logic [ACC_W-1:0]          w_prod_acc, w_acc_init;

  assign w_x_ext    = {{WIDTH{x_data[WIDTH-1]}}, x_data};
  assign w_w_ext    = {{WIDTH{w_data[WIDTH-1]}}, w_data};
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_acc = {{EXT_W{w_prod[2*WIDTH-1]}}, w_prod};

`ifdef FC_BIAS_EN
  assign w_acc_init = {{EXT_W{b_data[2*WIDTH-1]}}, b_data};
`else
  assign w_acc_init = '0;
`endif

  // The accumulator is (re)loaded on the first RUN cycle of each neuron so
  // that a bias derived from n always sees the neuron now being computed.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    acc_d   = acc_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          n_d     = '0;
          acc_d   = w_acc_init;
        end
      end
      S_RUN: begin
        if (k_q == '0) acc_d = w_acc_init;
        else           acc_d = acc_q + w_prod_acc;
        if (k_q == KW'(IN - 1)) state_d = S_DRAIN;
        else                    k_d     = k_q + 1'b1;
      end
      S_DRAIN: begin
        acc_d   = acc_q + w_prod_acc;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          k_d = '0;
          if (n_q == NW'(OUT - 1)) begin
            done    = ~rst;
            n_d     = '0;
            state_d = S_IDLE;
          end else begin
            n_d     = n_q + 1'b1;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
    end
  end

  // Addresses hold their last RUN value through DRAIN and EMIT.
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_EMIT);
  assign out_idx   = n_q;
  assign x_addr    = busy ? k_q : '0;
  assign w_addr    = busy ? (AW'(n_q) * AW'(IN) + AW'(k_q)) : '0;

  relu #(
    .WIDTH (ACC_W)
  ) u_relu (
    .a   (acc_q),
    .b   ({ACC_W{1'b0}}),
    .sel (acc_q[ACC_W-1]),
    .y   (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fc_sequencer.sv
// +-------------------------------------------------------------------------+
// | tb_fc_sequencer : directed vector bench for fc_sequencer (IN=4, OUT=2)  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_fc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, out_valid;
  logic [1:0]  x_addr;
  logic [2:0]  w_addr;
  logic [7:0]  x_data, w_data;
  logic [0:0]  out_idx;
  logic [17:0] out_data;
  logic [15:0] cur_b0, cur_b1;

  always #5 clk = ~clk;

  fc_sequencer #(.WIDTH(8), .IN(4), .OUT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
`ifdef FC_BIAS_EN
    .b_data    ((out_idx == 1'b0) ? cur_b0 : cur_b1),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  // Activation buffer and weight ROM: one-cycle read latency.
  logic [7:0] x_mem [4];
  logic [7:0] w_mem [8];
  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    w_data <= w_mem[w_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] x;      // x[0] in the low byte
    logic [63:0] w;      // neuron 0 in the low 32 bits
    logic [15:0] b0;
    logic [15:0] b1;
    logic [7:0]  stall;
    logic        glitch;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] lat;
  } vec_t;

  vec_t vecs [8];
  int   nvec;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int     t0, lat, nhs, stalled;
    longint s_idx, s_data, s_x, s_w;
    for (int i = 0; i < 4; i++) x_mem[i] = v.x[8*i +: 8];
    for (int i = 0; i < 8; i++) w_mem[i] = v.w[8*i +: 8];
    cur_b0 = v.b0;
    cur_b1 = v.b1;
    s_idx = 0; s_data = 0; s_x = 0; s_w = 0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; t0 = cyc;
    lat = -1; nhs = 0; stalled = 0;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      @(negedge clk);
      start = v.glitch && ((cyc - t0 == 3) || (out_valid && out_idx == 1'b1));
      if (out_valid && stalled < int'(v.stall)) begin
        if (stalled == 0) begin
          s_idx = longint'(out_idx); s_data = longint'(out_data);
          s_x = longint'(x_addr);    s_w = longint'(w_addr);
        end else begin
          chk($sformatf("v%0d hold_valid", id), longint'(out_valid), 1);
          chk($sformatf("v%0d hold_idx", id), longint'(out_idx), s_idx);
          chk($sformatf("v%0d hold_data", id), longint'(out_data), s_data);
          chk($sformatf("v%0d hold_xaddr", id), longint'(x_addr), s_x);
          chk($sformatf("v%0d hold_waddr", id), longint'(w_addr), s_w);
        end
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        nhs++;
        chk($sformatf("v%0d idx%0d", id, nhs - 1), longint'(out_idx), longint'(nhs - 1));
        chk($sformatf("v%0d data%0d", id, nhs - 1), longint'(out_data),
            (nhs == 1) ? longint'(v.e0) : longint'(v.e1));
      end
      if (done) lat = cyc - t0;
    end
    chk($sformatf("v%0d latency", id), longint'(lat), longint'(v.lat));
    chk($sformatf("v%0d handshakes", id), longint'(nhs), 2);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d done_width", id), longint'(done), 0);
    chk($sformatf("v%0d idle_after", id), longint'(busy), 0);
    out_ready = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},      longint'(busy), 0);
    chk({tag, " done"},      longint'(done), 0);
    chk({tag, " out_valid"}, longint'(out_valid), 0);
    chk({tag, " out_idx"},   longint'(out_idx), 0);
    chk({tag, " out_data"},  longint'(out_data), 0);
    chk({tag, " x_addr"},    longint'(x_addr), 0);
    chk({tag, " w_addr"},    longint'(w_addr), 0);
  endtask

  initial begin
    int  found, seen_done;
    logic [63:0] w_basic;
    w_basic = {pk4(-1, -1, -1, -1), pk4(1, 1, 1, 1)};
    vecs[0] = '{pk4(1, 2, 3, 4), w_basic, 16'd0, 16'd0, 8'd0, 1'b0, 32'd10, 32'd0, 32'd12};
    vecs[1] = '{pk4(-128, -128, -128, -128),
                {pk4(-128, -128, -128, -128), pk4(-128, -128, -128, -128)},
                16'd0, 16'd0, 8'd0, 1'b0, 32'd65536, 32'd65536, 32'd12};
    vecs[2] = '{pk4(1, 2, 3, 4), w_basic, 16'd0, 16'd0, 8'd5, 1'b0, 32'd10, 32'd0, 32'd17};
    vecs[3] = '{pk4(1, 2, 3, 4), w_basic, 16'd0, 16'd0, 8'd0, 1'b1, 32'd10, 32'd0, 32'd12};
    vecs[4] = '{pk4(5, -3, 7, 0), {pk4(-2, -4, 1, 3), pk4(2, 4, -1, 9)},
                16'd0, 16'd0, 8'd0, 1'b0, 32'd0, 32'd9, 32'd12};
    vecs[5] = '{pk4(127, 127, 127, 127), {pk4(127, 127, 127, -128), pk4(127, 127, 127, 127)},
                16'd0, 16'd0, 8'd0, 1'b0, 32'd64516, 32'd32131, 32'd12};
    nvec = 6;
`ifdef FC_BIAS_EN
    vecs[6] = '{pk4(1, 2, 3, 4), w_basic, -16'sd20, 16'sd5, 8'd0, 1'b0, 32'd0, 32'd0, 32'd12};
    vecs[7] = '{pk4(1, 2, 3, 4), w_basic, 16'sd100, 16'sd7, 8'd0, 1'b0, 32'd110, 32'd0, 32'd12};
    nvec = 8;
`endif

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    cur_b0 = '0; cur_b1 = '0;
    for (int i = 0; i < 4; i++) x_mem[i] = '0;
    for (int i = 0; i < 8; i++) w_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // Reset in the middle of neuron 1 at k=2.
    for (int i = 0; i < 4; i++) x_mem[i] = vecs[0].x[8*i +: 8];
    for (int i = 0; i < 8; i++) w_mem[i] = vecs[0].w[8*i +: 8];
    cur_b0 = '0; cur_b1 = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (busy && !out_valid && out_idx == 1'b1 && x_addr == 2'd2) found = 1;
      else @(negedge clk);
    end
    chk("rst_mid reached", longint'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid");
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    chk("rst_mid no_done", longint'(seen_done), 0);
    run_vec(vecs[0], 99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
